// File: rtl/rv32_alu_arb_pkg.sv
// rv32_alu_arb_pkg: shared types and constants for the ALU arbiter and its response FIFO.
// ALU op encodings mirror the rv32_alu decoder (funct3 order).
package rv32_alu_arb_pkg;
  localparam logic [3:0] RV32_ALU_OP_ADD_SUB = 4'd0;
  localparam logic [3:0] RV32_ALU_OP_SLL     = 4'd1;
  localparam logic [3:0] RV32_ALU_OP_SLT     = 4'd2;
  localparam logic [3:0] RV32_ALU_OP_SLTU    = 4'd3;
  localparam logic [3:0] RV32_ALU_OP_XOR     = 4'd4;
  localparam logic [3:0] RV32_ALU_OP_SRL_SRA = 4'd5;
  localparam logic [3:0] RV32_ALU_OP_OR      = 4'd6;
  localparam logic [3:0] RV32_ALU_OP_AND     = 4'd7;

  localparam logic RV32_ALU_REQ_EXEC = 1'b0;
  localparam logic RV32_ALU_REQ_AUX  = 1'b1;

  localparam int RV32_ALU_TAG_W = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic        sub_sra;
    logic        src1;
    logic        src2;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } alu_req_t;

  typedef struct packed {
    logic                      id;
    logic [RV32_ALU_TAG_W-1:0] tag;
    logic [31:0]               result;
  } alu_resp_t;
endpackage

// File: rtl/rv32_alu_resp_fifo.sv
// rv32_alu_resp_fifo: small in-order response queue with synchronous clear.
module rv32_alu_resp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           wdata_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= nxt(wr_q);
      if (pop_i) rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/rv32_alu_arbiter.sv
// rv32_alu_arbiter: round-robin sharing of one registered ALU between execute and aux,
// returning results in issue order through a response FIFO.
module rv32_alu_arbiter
  import rv32_alu_arb_pkg::*;
#(
  parameter int RESP_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_in,
  input  logic [1:0]            req_valid_in,
  output logic [1:0]            req_ready_out,
  input  logic [1:0][3:0]       req_op_in,
  input  logic [1:0]            req_sub_sra_in,
  input  logic [1:0]            req_src1_in,
  input  logic [1:0]            req_src2_in,
  input  logic [1:0][31:0]      req_pc_in,
  input  logic [1:0][31:0]      req_rs1_in,
  input  logic [1:0][31:0]      req_rs2_in,
  input  logic [1:0][31:0]      req_imm_in,
  input  logic [1:0][TAG_W-1:0] req_tag_in,
  output logic [3:0]            alu_op_out,
  output logic                  alu_sub_sra_out,
  output logic                  alu_src1_out,
  output logic                  alu_src2_out,
  output logic [31:0]           alu_pc_out,
  output logic [31:0]           alu_rs1_out,
  output logic [31:0]           alu_rs2_out,
  output logic [31:0]           alu_imm_out,
  input  logic [31:0]           alu_result_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic                  resp_id_out,
  output logic [TAG_W-1:0]      resp_tag_out,
  output logic [31:0]           resp_result_out
);
  localparam int CW = $clog2(RESP_DEPTH+1);

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      result;
  } resp_t;

  logic            inflight_q, inflight_d, last_q, last_d;
  logic [TAG_W:0]  pend_q, pend_d;
  logic            pop, space, gnt, gnt_id, sel, cap_push;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  resp_t           head, wdata;
  alu_req_t        mux;

  // Occupancy counts the result already in the ALU pipe so capture never overflows.
  assign pop   = resp_valid_out & resp_ready_in;
  assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign space = occ < (CW+1)'(RESP_DEPTH);

  always_comb begin
    gnt           = |req_valid_in & space & ~flush_in;
    gnt_id        = &req_valid_in ? ~last_q : req_valid_in[1];
    req_ready_out = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    inflight_d    = gnt;
    last_d        = gnt ? gnt_id : last_q;
    pend_d        = gnt ? {gnt_id, req_tag_in[gnt_id]} : pend_q;
    sel           = gnt & gnt_id;
  end

  assign mux = '{op: req_op_in[sel], sub_sra: req_sub_sra_in[sel], src1: req_src1_in[sel],
                 src2: req_src2_in[sel], pc: req_pc_in[sel], rs1: req_rs1_in[sel],
                 rs2: req_rs2_in[sel], imm: req_imm_in[sel]};

  assign alu_op_out      = mux.op;
  assign alu_sub_sra_out = mux.sub_sra;
  assign alu_src1_out    = mux.src1;
  assign alu_src2_out    = mux.src2;
  assign alu_pc_out      = mux.pc;
  assign alu_rs1_out     = mux.rs1;
  assign alu_rs2_out     = mux.rs2;
  assign alu_imm_out     = mux.imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      last_q     <= 1'b1;
      pend_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
    end
  end

  assign cap_push = inflight_q & ~flush_in;
  assign wdata    = '{id: pend_q[TAG_W], tag: pend_q[TAG_W-1:0], result: alu_result_in};

  rv32_alu_resp_fifo #(.DEPTH(RESP_DEPTH), .T(resp_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush_in),
    .push_i  (cap_push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  assign resp_valid_out  = count != '0;
  assign resp_id_out     = head.id;
  assign resp_tag_out    = head.tag;
  assign resp_result_out = head.result;
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// tb_rv32_alu_arbiter: scenario tasks plus randomized traffic checked against a
// queue-based model of issue order, 2-cycle latency and round-robin arbitration.
module tb_rv32_alu_arbiter;
  import rv32_alu_arb_pkg::*;
  localparam int DEPTH = 2;
  localparam int TW = 4;

  logic clk = 0, rst_n = 0, flush = 0, resp_ready = 0;
  logic [1:0] req_valid = '0, req_ready;
  logic [1:0][3:0] req_op = '0;
  logic [1:0] req_sub = '0, req_s1 = '0, req_s2 = '0;
  logic [1:0][31:0] req_pc = '0, req_rs1 = '0, req_rs2 = '0, req_imm = '0;
  logic [1:0][TW-1:0] req_tag = '0;
  logic [3:0] alu_op;
  logic alu_sub, alu_s1, alu_s2;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm, alu_res;
  logic resp_valid, resp_id;
  logic [TW-1:0] resp_tag;
  logic [31:0] resp_result;

  always #5 clk = ~clk;

  rv32_alu_arbiter #(.RESP_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_op_in(req_op), .req_sub_sra_in(req_sub), .req_src1_in(req_s1), .req_src2_in(req_s2),
    .req_pc_in(req_pc), .req_rs1_in(req_rs1), .req_rs2_in(req_rs2), .req_imm_in(req_imm),
    .req_tag_in(req_tag),
    .alu_op_out(alu_op), .alu_sub_sra_out(alu_sub), .alu_src1_out(alu_s1), .alu_src2_out(alu_s2),
    .alu_pc_out(alu_pc), .alu_rs1_out(alu_rs1), .alu_rs2_out(alu_rs2), .alu_imm_out(alu_imm),
    .alu_result_in(alu_res),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_id_out(resp_id), .resp_tag_out(resp_tag), .resp_result_out(resp_result)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      RV32_ALU_OP_ADD_SUB: return sub ? a - b : a + b;
      RV32_ALU_OP_SLL:     return a << b[4:0];
      RV32_ALU_OP_SLT:     return {31'b0, $signed(a) < $signed(b)};
      RV32_ALU_OP_SLTU:    return {31'b0, a < b};
      RV32_ALU_OP_XOR:     return a ^ b;
      RV32_ALU_OP_SRL_SRA: return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      RV32_ALU_OP_OR:      return a | b;
      RV32_ALU_OP_AND:     return a & b;
      default:             return 32'h0;
    endcase
  endfunction

  // Stand-in for the registered rv32_alu
  always_ff @(posedge clk)
    alu_res <= alu_ref(alu_op, alu_sub, alu_s1 ? alu_pc : alu_rs1, alu_s2 ? alu_imm : alu_rs2);

  typedef struct {bit id; logic [TW-1:0] tag; logic [31:0] res; int cyc;} ent_t;
  ent_t q[$];
  ent_t exp_head;
  bit m_last = 1, m_pop, m_gnt, m_gid, exp_valid;
  logic [1:0] exp_ready;
  int cyc = 0;
  logic [1:0] obs_ready;
  logic obs_valid, obs_id;
  logic [TW-1:0] obs_tag;
  logic [31:0] obs_res;
  int compared = 0, mismatched = 0;

  // A granted request becomes visible two cycles after its issue cycle.
  function automatic void model_eval();
    exp_valid = q.size() > 0 && cyc >= q[0].cyc + 2;
    m_pop = exp_valid && resp_ready;
    m_gnt = |req_valid && !flush && (q.size() - int'(m_pop)) < DEPTH;
    m_gid = (&req_valid) ? !m_last : req_valid[1];
    exp_ready = m_gnt ? (m_gid ? 2'b10 : 2'b01) : 2'b00;
    if (exp_valid) exp_head = q[0];
  endfunction

  task automatic model_commit();
    ent_t e;
    if (flush) q.delete();
    else begin
      if (m_pop) void'(q.pop_front());
      if (m_gnt) begin
        e.id = m_gid;
        e.tag = req_tag[m_gid];
        e.res = alu_ref(req_op[m_gid], req_sub[m_gid], req_s1[m_gid] ? req_pc[m_gid] : req_rs1[m_gid],
                        req_s2[m_gid] ? req_imm[m_gid] : req_rs2[m_gid]);
        e.cyc = cyc;
        q.push_back(e);
        m_last = m_gid;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    obs_ready = req_ready;
    obs_valid = resp_valid;
    obs_id = resp_id;
    obs_tag = resp_tag;
    obs_res = resp_result;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic rand_req(input int i);
    req_op[i] = 4'($urandom_range(0, 7));
    req_sub[i] = 1'($urandom);
    req_s1[i] = 1'($urandom);
    req_s2[i] = 1'($urandom);
    req_pc[i] = $urandom;
    req_rs1[i] = $urandom;
    req_rs2[i] = $urandom;
    req_imm[i] = $urandom;
    req_tag[i] = 4'($urandom);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tag);
    rand_req(i);
    req_op[i] = op;
    req_sub[i] = 1'b0;
    req_s1[i] = 1'b0;
    req_s2[i] = 1'b0;
    req_rs1[i] = a;
    req_rs2[i] = b;
    req_tag[i] = tag;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    flush = 0;
    resp_ready = 1;
    repeat (n) cycle();
  endtask

  always @(negedge clk)
    if (rst_n && dut.cap_push && !dut.pop && int'(dut.count) == DEPTH) begin
      mismatched++;
      $display("FAIL fifo_push_when_full: count=%0d push=1 pop=0", dut.count);
    end

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (req_ready !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    compared++;
    if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alternate();
    bit ids[$];
    resp_ready = 1;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 2'b11 : 2'b00;
      rand_req(0);
      rand_req(1);
      cycle();
      if (k < 6) begin
        compared++;
        if (obs_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
          mismatched++; $display("FAIL alt_grant%0d: got %b want %b", k, obs_ready, (k % 2) ? 2'b10 : 2'b01);
        end
      end
      compared++;
      if (obs_valid !== (k >= 2)) begin mismatched++; $display("FAIL alt_valid%0d: got %b want %b", k, obs_valid, k >= 2); end
      if (obs_valid && exp_valid) begin
        ids.push_back(obs_id);
        compared++;
        if ({obs_id, obs_tag, obs_res} !== {exp_head.id, exp_head.tag, exp_head.res}) begin
          mismatched++;
          $display("FAIL alt_resp%0d: got id%0d tag%h res%h want id%0d tag%h res%h", k, obs_id, obs_tag, obs_res,
                   exp_head.id, exp_head.tag, exp_head.res);
        end
      end
    end
    compared++;
    if (ids.size() != 6) begin mismatched++; $display("FAIL alt_count: got %0d want 6", ids.size()); end
    foreach (ids[i]) begin
      compared++;
      if (ids[i] != bit'(i % 2)) begin mismatched++; $display("FAIL alt_order%0d: got id%0d want id%0d", i, ids[i], i % 2); end
    end
  endtask

  task automatic test_single();
    resp_ready = 1;
    set_req(0, RV32_ALU_OP_ADD_SUB, 32'd5, 32'd7, 4'h3);
    req_valid = 2'b01;
    cycle();
    compared++;
    if (obs_ready !== 2'b01) begin mismatched++; $display("FAIL single_grant: got %b want 01", obs_ready); end
    req_valid = 2'b00;
    cycle();
    compared++;
    if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL single_early: got %b want 0", obs_valid); end
    cycle();
    compared++;
    if ({obs_valid, obs_id, obs_tag, obs_res} !== {1'b1, 1'b0, 4'h3, 32'd12}) begin
      mismatched++;
      $display("FAIL single_resp: got v%b id%0d tag%h res%0d want v1 id0 tag3 res12", obs_valid, obs_id, obs_tag, obs_res);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    int grants = 0;
    resp_ready = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rand_req(0);
      rand_req(1);
      cycle();
      if (obs_ready != 2'b00) grants++;
      compared++;
      if (obs_ready !== exp_ready) begin mismatched++; $display("FAIL bp_ready%0d: got %b want %b", k, obs_ready, exp_ready); end
    end
    compared++;
    if (grants != DEPTH) begin mismatched++; $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH); end
    compared++;
    if (obs_ready !== 2'b00) begin mismatched++; $display("FAIL bp_stall: got %b want 00", obs_ready); end
    req_valid = 2'b00;
    resp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if (obs_valid !== (k < 2)) begin mismatched++; $display("FAIL bp_drain%0d: got %b want %b", k, obs_valid, k < 2); end
      if (obs_valid && exp_valid) begin
        compared++;
        if ({obs_id, obs_tag, obs_res} !== {exp_head.id, exp_head.tag, exp_head.res}) begin
          mismatched++; $display("FAIL bp_resp%0d: got res%h want res%h", k, obs_res, exp_head.res);
        end
      end
    end
    req_valid = 2'b11;
    cycle();
    compared++;
    if (obs_ready === 2'b00 || obs_ready !== exp_ready) begin
      mismatched++; $display("FAIL bp_resume: got %b want %b", obs_ready, exp_ready);
    end
    idle(4);
  endtask

  task automatic test_flush();
    bit seen = 0;
    resp_ready = 0;
    set_req(0, RV32_ALU_OP_XOR, $urandom, $urandom, 4'h1);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();
    set_req(0, RV32_ALU_OP_OR, $urandom, $urandom, 4'h2);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    flush = 1;
    cycle();
    flush = 0;
    cycle();
    compared++;
    if (obs_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %b want 0", obs_valid); end
    resp_ready = 1;
    set_req(1, RV32_ALU_OP_AND, $urandom, $urandom, 4'h9);
    req_valid = 2'b10;
    cycle();
    req_valid = 2'b00;
    for (int k = 0; k < 5 && !seen; k++) begin
      cycle();
      if (obs_valid) begin
        seen = 1;
        compared++;
        if ({obs_id, obs_tag, obs_res} !== {1'b1, 4'h9, req_rs1[1] & req_rs2[1]}) begin
          mismatched++;
          $display("FAIL flush_first: got id%0d tag%h res%h want id1 tag9 res%h", obs_id, obs_tag, obs_res,
                   req_rs1[1] & req_rs2[1]);
        end
      end
    end
    if (!seen) begin compared++; mismatched++; $display("FAIL flush_timeout: got no response want one"); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    resp_ready = 0;
    req_valid = 2'b11;
    rand_req(0);
    rand_req(1);
    cycle();
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();
    compared++;
    if (obs_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_full: got %b want 1", obs_valid); end
    rst_n = 0;
    #1;
    compared++;
    if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b want 0", resp_valid); end
    q.delete();
    m_last = 1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    resp_ready = 1;
    req_valid = 2'b11;
    rand_req(0);
    rand_req(1);
    cycle();
    compared++;
    if (obs_ready !== 2'b01) begin mismatched++; $display("FAIL rstmid_first: got %b want 01", obs_ready); end
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if (obs_valid !== (k == 1)) begin mismatched++; $display("FAIL rstmid_resp%0d: got %b want %b", k, obs_valid, k == 1); end
    end
  endtask

  task automatic test_slt();
    resp_ready = 1;
    set_req(1, RV32_ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'hA);
    req_valid = 2'b10;
    cycle();
    compared++;
    if (obs_ready !== 2'b10) begin mismatched++; $display("FAIL slt_grant: got %b want 10", obs_ready); end
    req_valid = 2'b00;
    cycle();
    cycle();
    compared++;
    if ({obs_valid, obs_id, obs_tag, obs_res} !== {1'b1, 1'b1, 4'hA, 32'd1}) begin
      mismatched++;
      $display("FAIL slt_resp: got v%b id%0d tag%h res%0d want v1 id1 tagA res1", obs_valid, obs_id, obs_tag, obs_res);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = 2'($urandom_range(0, 3));
      rand_req(0);
      rand_req(1);
      resp_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      cycle();
      compared++;
      if (obs_ready !== exp_ready) begin mismatched++; $display("FAIL rnd_ready%0d: got %b want %b", k, obs_ready, exp_ready); end
      compared++;
      if (obs_valid !== exp_valid) begin mismatched++; $display("FAIL rnd_valid%0d: got %b want %b", k, obs_valid, exp_valid); end
      if (exp_valid) begin
        compared++;
        if ({obs_id, obs_tag, obs_res} !== {exp_head.id, exp_head.tag, exp_head.res}) begin
          mismatched++;
          $display("FAIL rnd_resp%0d: got id%0d tag%h res%h want id%0d tag%h res%h", k, obs_id, obs_tag, obs_res,
                   exp_head.id, exp_head.tag, exp_head.res);
        end
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_slt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
